// File: rtl/date_edit_pkg.sv
// Shared types and BCD limits for the RTC date editor.
package date_edit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EDIT,
    COMMIT
  } state_t;

  typedef enum logic [1:0] {
    F_DAY,
    F_MON,
    F_YEAR
  } field_t;

  localparam int CUR_DAY  = 3;
  localparam int CUR_MON  = 4;
  localparam int CUR_YEAR = 5;

  localparam logic [7:0] DAY_MIN  = 8'h01;
  localparam logic [7:0] DAY_MAX  = 8'h31;
  localparam logic [7:0] MON_MIN  = 8'h01;
  localparam logic [7:0] MON_MAX  = 8'h12;
  localparam logic [7:0] YEAR_MIN = 8'h00;
  localparam logic [7:0] YEAR_MAX = 8'h99;

  localparam logic [0:11][7:0] DIM_TAB = {
    8'h31, 8'h28, 8'h31, 8'h30, 8'h31, 8'h30,
    8'h31, 8'h31, 8'h30, 8'h31, 8'h30, 8'h31
  };

  function automatic logic [7:0] days_in_month(
    input logic [7:0] m,
    input logic [4:0] ylo
  );
    logic [7:0] mb;
    logic       leap;
    logic [7:0] res;
    mb = {4'h0, m[7:4]} * 8'd10 + {4'h0, m[3:0]};
    // BCD year divisible by 4: even tens -> 0/4/8, odd tens -> 2/6
    leap = ylo[4] ? (ylo[3:0] == 4'd2 || ylo[3:0] == 4'd6)
                  : (ylo[3:0] == 4'd0 || ylo[3:0] == 4'd4 ||
                     ylo[3:0] == 4'd8);
    res = DAY_MAX;
    if (m[7:4] <= 4'd9 && m[3:0] <= 4'd9 &&
        mb >= 8'd1 && mb <= 8'd12) begin
      res = DIM_TAB[4'(mb - 8'd1)];
      if (mb == 8'd2 && leap) res = 8'h29;
    end
    return res;
  endfunction

endpackage

// File: rtl/date_edit_ctrl_if.sv
// RTC write port: edited date bytes plus req/ack/err handshake.
interface date_edit_ctrl_if;
  logic [7:0] fecha_out1;
  logic [7:0] fecha_out2;
  logic [7:0] fecha_out3;
  logic       wr_req;
  logic       wr_ack;
  logic       wr_err;

  modport master (
    output fecha_out1, fecha_out2, fecha_out3,
    output wr_req, wr_err,
    input  wr_ack
  );

  modport slave (
    input  fecha_out1, fecha_out2, fecha_out3,
    input  wr_req, wr_err,
    output wr_ack
  );
endinterface

// File: rtl/bcd_field_step.sv
// Packed-BCD inc/dec with min/max wrap; invalid input snaps to min/max.
module bcd_field_step (
  input  logic [7:0] val,
  input  logic [7:0] lo,
  input  logic [7:0] hi,
  input  logic       inc,
  output logic [7:0] res
);
  logic ok;

  assign ok = (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) &&
              (val >= lo) && (val <= hi);

  always_comb begin
    res = val;
    if (inc) begin
      if (!ok || val == hi)
        res = lo;
      else if (val[3:0] == 4'd9)
        res = {val[7:4] + 4'd1, 4'd0};
      else
        res = {val[7:4], val[3:0] + 4'd1};
    end else begin
      if (!ok || val == lo)
        res = hi;
      else if (val[3:0] == 4'd0)
        res = {val[7:4] - 4'd1, 4'd9};
      else
        res = {val[7:4], val[3:0] - 4'd1};
    end
  end
endmodule

// File: rtl/date_edit_ctrl.sv
// RTC date editor with req/ack commit. Optional day clamp to the
// month length is enabled by defining DATE_EDIT_DAYCLAMP_EN.
module date_edit_ctrl
  import date_edit_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1023,
  parameter int CUR_FIRST   = CUR_DAY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             programar_on,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic [7:0]       fecha_in1,
  input  logic [7:0]       fecha_in2,
  input  logic [7:0]       fecha_in3,
  output logic [3:0]       direccion_actual_pantalla,
  output logic             edit_busy,
  date_edit_ctrl_if.master rtc
);
  localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      state_q, state_n;
  field_t      cur_q, cur_n;
  logic [7:0]  day_q, mon_q, year_q;
  logic [7:0]  day_n, mon_n, year_n;
  logic [15:0] cnt_q, cnt_n;
  logic [3:0]  btn_q, btn_now, ev;
  logic        req_q, req_n, err_q, err_n, busy_q, busy_n;
  logic        ev_up, ev_dn, ev_l, ev_r, v_any, h_one;
  logic [7:0]  day_max;
  logic        clamp;
  logic [7:0]  s_val, s_lo, s_hi, s_res;

  assign btn_now = {btn_up, btn_down, btn_left, btn_right};
  assign ev      = btn_now & ~btn_q;
  assign ev_up   = ev[3];
  assign ev_dn   = ev[2];
  assign ev_l    = ev[1];
  assign ev_r    = ev[0];
  assign v_any   = ev_up | ev_dn;
  assign h_one   = (ev_l ^ ev_r) & ~v_any;

`ifdef DATE_EDIT_DAYCLAMP_EN
  assign day_max = days_in_month(mon_q, year_q[4:0]);
  assign clamp   = (day_q > day_max);
`else
  assign day_max = DAY_MAX;
  assign clamp   = 1'b0;
`endif

  always_comb begin
    s_val = year_q;
    s_lo  = YEAR_MIN;
    s_hi  = YEAR_MAX;
    unique case (cur_q)
      F_DAY: begin
        s_val = day_q;
        s_lo  = DAY_MIN;
        s_hi  = day_max;
      end
      F_MON: begin
        s_val = mon_q;
        s_lo  = MON_MIN;
        s_hi  = MON_MAX;
      end
      default: ;
    endcase
  end

  bcd_field_step u_step (
    .val (s_val),
    .lo  (s_lo),
    .hi  (s_hi),
    .inc (ev_up),
    .res (s_res)
  );

  always_comb begin
    state_n = state_q;
    cur_n   = cur_q;
    day_n   = day_q;
    mon_n   = mon_q;
    year_n  = year_q;
    cnt_n   = cnt_q;
    err_n   = 1'b0;
    unique case (state_q)
      IDLE: begin
        day_n  = fecha_in1;
        mon_n  = fecha_in2;
        year_n = fecha_in3;
        cur_n  = F_DAY;
        cnt_n  = '0;
        if (programar_on) state_n = EDIT;
      end
      EDIT: begin
        cnt_n = '0;
        if (!programar_on) begin
          // hold off the commit until a pending clamp lands
          if (!clamp) state_n = COMMIT;
        end else begin
          unique case (1'b1)
            v_any: begin
              if (ev_up ^ ev_dn) begin
                unique case (cur_q)
                  F_DAY:   day_n  = s_res;
                  F_MON:   mon_n  = s_res;
                  default: year_n = s_res;
                endcase
              end
            end
            h_one: begin
              unique case (cur_q)
                F_DAY:   cur_n = ev_r ? F_MON  : F_YEAR;
                F_MON:   cur_n = ev_r ? F_YEAR : F_DAY;
                default: cur_n = ev_r ? F_DAY  : F_MON;
              endcase
            end
            default: ;
          endcase
        end
        if (clamp) day_n = day_max;
      end
      COMMIT: begin
        if (rtc.wr_ack) begin
          state_n = IDLE;
        end else if (cnt_q == TO_LAST) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt_q + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    req_n  = (state_n == COMMIT);
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cur_q   <= F_DAY;
      day_q   <= 8'h00;
      mon_q   <= 8'h00;
      year_q  <= 8'h00;
      cnt_q   <= '0;
      btn_q   <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cur_q   <= cur_n;
      day_q   <= day_n;
      mon_q   <= mon_n;
      year_q  <= year_n;
      cnt_q   <= cnt_n;
      btn_q   <= btn_now;
      req_q   <= req_n;
      err_q   <= err_n;
      busy_q  <= busy_n;
    end
  end

  assign rtc.fecha_out1 = day_q;
  assign rtc.fecha_out2 = mon_q;
  assign rtc.fecha_out3 = year_q;
  assign rtc.wr_req     = req_q;
  assign rtc.wr_err     = err_q;
  assign edit_busy      = busy_q;
  assign direccion_actual_pantalla = 4'(CUR_FIRST) + {2'b00, cur_q};

endmodule

// File: tb/tb_date_edit_ctrl.sv
// Directed, table-driven bench for date_edit_ctrl.
module tb_date_edit_ctrl;

  typedef struct {
    logic       up, dn, l, r;
    logic [7:0] d, m, y;
    logic [3:0] cur;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       programar_on;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic [7:0] fecha_in1, fecha_in2, fecha_in3;
  logic [3:0] direccion_actual_pantalla;
  logic       edit_busy;

  int n_vec;
  int n_bad;
  int reqcnt;
  int errcnt;

  vec_t tab [21];

  date_edit_ctrl_if rtc ();

  date_edit_ctrl #(
    .ACK_TIMEOUT (8),
    .CUR_FIRST   (3)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .programar_on              (programar_on),
    .btn_up                    (btn_up),
    .btn_down                  (btn_down),
    .btn_left                  (btn_left),
    .btn_right                 (btn_right),
    .fecha_in1                 (fecha_in1),
    .fecha_in2                 (fecha_in2),
    .fecha_in3                 (fecha_in3),
    .direccion_actual_pantalla (direccion_actual_pantalla),
    .edit_busy                 (edit_busy),
    .rtc                       (rtc.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic u, input logic d,
                       input logic l, input logic r);
    btn_up    = u;
    btn_down  = d;
    btn_left  = l;
    btn_right = r;
    tick();
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] outs();
    return {4'h0, rtc.fecha_out1, rtc.fecha_out2,
            rtc.fecha_out3, direccion_actual_pantalla};
  endfunction

  task automatic set_in(input logic [7:0] d, input logic [7:0] m,
                        input logic [7:0] y);
    fecha_in1 = d;
    fecha_in2 = m;
    fecha_in3 = y;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    //           up   dn   l    r    day    mon    year   cur
    tab[0]  = '{1'b1,1'b0,1'b0,1'b0,8'h01,8'h01,8'h24,4'd3};
    tab[1]  = '{1'b1,1'b0,1'b0,1'b0,8'h02,8'h01,8'h24,4'd3};
    tab[2]  = '{1'b0,1'b0,1'b0,1'b1,8'h02,8'h01,8'h24,4'd4};
    tab[3]  = '{1'b0,1'b1,1'b0,1'b0,8'h02,8'h12,8'h24,4'd4};
    tab[4]  = '{1'b0,1'b0,1'b1,1'b0,8'h02,8'h12,8'h24,4'd3};
    tab[5]  = '{1'b0,1'b0,1'b1,1'b0,8'h02,8'h12,8'h24,4'd5};
    tab[6]  = '{1'b1,1'b1,1'b0,1'b0,8'h02,8'h12,8'h24,4'd5};
    tab[7]  = '{1'b1,1'b0,1'b0,1'b1,8'h02,8'h12,8'h25,4'd5};
    tab[8]  = '{1'b0,1'b1,1'b0,1'b0,8'h02,8'h12,8'h24,4'd5};
    tab[9]  = '{1'b0,1'b0,1'b0,1'b1,8'h02,8'h12,8'h24,4'd3};
    tab[10] = '{1'b0,1'b0,1'b1,1'b1,8'h02,8'h12,8'h24,4'd3};
    tab[11] = '{1'b0,1'b1,1'b0,1'b0,8'h01,8'h12,8'h24,4'd3};
    tab[12] = '{1'b0,1'b1,1'b0,1'b0,8'h31,8'h12,8'h24,4'd3};
    tab[13] = '{1'b1,1'b0,1'b0,1'b0,8'h01,8'h12,8'h24,4'd3};
    tab[14] = '{1'b1,1'b0,1'b0,1'b0,8'h02,8'h12,8'h24,4'd3};
    // second session starts from 1F/13/99 (non-BCD day, bad month)
    tab[15] = '{1'b1,1'b0,1'b0,1'b0,8'h01,8'h13,8'h99,4'd3};
    tab[16] = '{1'b0,1'b0,1'b0,1'b1,8'h01,8'h13,8'h99,4'd4};
    tab[17] = '{1'b0,1'b1,1'b0,1'b0,8'h01,8'h12,8'h99,4'd4};
    tab[18] = '{1'b0,1'b0,1'b0,1'b1,8'h01,8'h12,8'h99,4'd5};
    tab[19] = '{1'b1,1'b0,1'b0,1'b0,8'h01,8'h12,8'h00,4'd5};
    tab[20] = '{1'b0,1'b1,1'b0,1'b0,8'h01,8'h12,8'h99,4'd5};

    reset        = 1'b0;
    programar_on = 1'b0;
    btn_up       = 1'b0;
    btn_down     = 1'b0;
    btn_left     = 1'b0;
    btn_right    = 1'b0;
    rtc.wr_ack   = 1'b0;
    set_in(8'h15, 8'h08, 8'h24);
    tick();
    tick();
    chk("reset_outs", outs(), {4'h0, 24'h000000, 4'd3});
    chk("reset_ctl", {29'd0, rtc.wr_req, rtc.wr_err, edit_busy}, 32'd0);

    reset = 1'b1;
    tick();
    chk("passthru", outs(), {4'h0, 24'h150824, 4'd3});
    chk("passthru_req", {31'd0, rtc.wr_req}, 32'd0);

    rtc.wr_ack = 1'b1;
    tick();
    chk("idle_ack_ignored", {30'd0, rtc.wr_req, rtc.wr_err}, 32'd0);
    rtc.wr_ack = 1'b0;

    set_in(8'h31, 8'h01, 8'h24);
    programar_on = 1'b1;
    tick();
    chk("edit_entry", outs(), {4'h0, 24'h310124, 4'd3});
    chk("edit_busy", {31'd0, edit_busy}, 32'd1);

    for (int i = 0; i < 15; i++) begin
      press(tab[i].up, tab[i].dn, tab[i].l, tab[i].r);
      chk($sformatf("vec%0d", i), outs(),
          {4'h0, tab[i].d, tab[i].m, tab[i].y, tab[i].cur});
    end

    programar_on = 1'b0;
    tick();
    chk("commit_req", {31'd0, rtc.wr_req}, 32'd1);
    chk("commit_data", outs(), {4'h0, 24'h021224, 4'd3});

    set_in(8'h11, 8'h11, 8'h11);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    chk("commit_frozen", outs(), {4'h0, 24'h021224, 4'd3});
    chk("commit_hold", {30'd0, rtc.wr_req, edit_busy}, 32'd3);
    tick();
    tick();
    tick();
    rtc.wr_ack = 1'b1;
    tick();
    rtc.wr_ack = 1'b0;
    chk("ack_drop", {29'd0, rtc.wr_req, rtc.wr_err, edit_busy}, 32'd0);
    tick();
    chk("resume_track", outs(), {4'h0, 24'h111111, 4'd3});

    set_in(8'h1F, 8'h13, 8'h99);
    programar_on = 1'b1;
    tick();
    chk("edit2_entry", outs(), {4'h0, 24'h1F1399, 4'd3});
    for (int i = 15; i < 21; i++) begin
      press(tab[i].up, tab[i].dn, tab[i].l, tab[i].r);
      chk($sformatf("vec%0d", i), outs(),
          {4'h0, tab[i].d, tab[i].m, tab[i].y, tab[i].cur});
    end

    programar_on = 1'b0;
    reqcnt = 0;
    errcnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rtc.wr_req) reqcnt++;
      if (rtc.wr_err) errcnt++;
    end
    chk("timeout_req_cycles", reqcnt, 8);
    chk("timeout_err_pulses", errcnt, 1);
    chk("timeout_track", outs(), {4'h0, 24'h1F1399, 4'd3});

    set_in(8'h05, 8'h06, 8'h07);
    programar_on = 1'b1;
    tick();
    programar_on = 1'b0;
    tick();
    chk("rst_mid_req", {31'd0, rtc.wr_req}, 32'd1);
    reset = 1'b0;
    tick();
    chk("rst_mid_outs", outs(), {4'h0, 24'h000000, 4'd3});
    chk("rst_mid_ctl", {29'd0, rtc.wr_req, rtc.wr_err, edit_busy}, 32'd0);
    reset = 1'b1;
    tick();
    chk("rst_after", {29'd0, rtc.wr_req, rtc.wr_err, edit_busy}, 32'd0);

`ifdef DATE_EDIT_DAYCLAMP_EN
    set_in(8'h31, 8'h03, 8'h24);
    programar_on = 1'b1;
    tick();
    press(1'b0, 1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    chk("clamp_feb_leap", outs(), {4'h0, 24'h290224, 4'd4});
    press(1'b0, 1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    chk("clamp_feb_common", outs(), {4'h0, 24'h280223, 4'd5});
    programar_on = 1'b0;
    tick();
    chk("clamp_commit", {31'd0, rtc.wr_req}, 32'd1);
    rtc.wr_ack = 1'b1;
    tick();
    rtc.wr_ack = 1'b0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/date_edit_ctrl.md
Name: date_edit_ctrl

Overview:
- Write-side counterpart of the on-screen date display: lets the user edit the RTC date (DD/MM/YY, packed BCD) while programming mode is on, then hands the edited bytes to the PicoBlaze RTC controller with a req/ack write handshake.
- Drives the cursor index consumed by the date display, using the same encoding: 3 = day, 4 = month, 5 = year.
- Outside programming mode it passes the live RTC date through, so the display can read its date from fecha_out* at all times.

Parameters:
- ACK_TIMEOUT, 1023: cycles to wait for wr_ack before aborting a commit; range 1..65535.
- CUR_FIRST, 3: cursor code of the day field; month = CUR_FIRST+1, year = CUR_FIRST+2.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-low; 0 = reset.
- programar_on, input, 1: programming mode level.
- btn_up, btn_down, btn_left, btn_right, input, 1 each: debounced, clk-synchronous levels; the block edge-detects them internally.
- fecha_in1, fecha_in2, fecha_in3, input, 8 each: live day, month, year from the RTC, packed BCD.
- wr_ack, input, 1: RTC controller has consumed fecha_out*.
- fecha_out1, fecha_out2, fecha_out3, output, 8 each: displayed/edited day, month, year, packed BCD.
- direccion_actual_pantalla, output, 4: cursor code.
- wr_req, output, 1: commit request.
- wr_err, output, 1: one-cycle pulse on ack timeout.
- edit_busy, output, 1: high in EDIT or COMMIT.

Behaviour:
- Reset values: fecha_out* = 8'h00, direccion_actual_pantalla = CUR_FIRST, wr_req = 0, wr_err = 0, edit_busy = 0. State = IDLE, timeout counter = 0, button edge history = 0.
- A reset asserted in any state, including mid-COMMIT, returns to IDLE and drops wr_req the next cycle. No write is issued.
- Button event = rising edge (level 1 now, 0 previous cycle). One event per press.
- State machine: IDLE, EDIT, COMMIT.
- IDLE:
  - fecha_outN <= fecha_inN every cycle (1-cycle latency).
  - Cursor is held at CUR_FIRST.
  - If programar_on = 1: load fecha_outN <= fecha_inN, set cursor = CUR_FIRST, go to EDIT.
- EDIT:
  - If programar_on = 0: go to COMMIT. Any button event in that cycle is ignored.
  - up/down inc/dec the field under the cursor, with BCD wrap:
    - day 01..31, month 01..12, year 00..99.
    - Inc of max gives min; dec of min gives max.
    - A field holding an out-of-range or non-BCD value becomes min on inc and max on dec.
  - left/right move the cursor 3→4→5→3 (right) or the reverse (left).
  - Both up and down in the same cycle: no change. Both left and right: no change.
  - Any vertical event in the same cycle as a horizontal event: only the vertical event is applied; the horizontal event is dropped.
  - Result is visible on fecha_out* the cycle after the edge.
- COMMIT:
  - wr_req = 1; fecha_out* are frozen and buttons are ignored.
  - wr_ack sampled high: drop wr_req next cycle, go to IDLE.
  - wr_ack high in the first COMMIT cycle is valid.
  - Timeout counter reaches ACK_TIMEOUT with no ack: drop wr_req, pulse wr_err for 1 cycle, go to IDLE. fecha_out* then resume tracking fecha_in*.
  - programar_on rising while in COMMIT has no effect until IDLE. IDLE then re-enters EDIT on the level.
- wr_ack outside COMMIT is ignored.
- edit_busy is a registered decode of the state.

Optional Feature:
- Macro: DATE_EDIT_DAYCLAMP_EN.
- Defined: the day maximum is the days-in-month for (month, year):
  - 31 for months 01/03/05/07/08/10/12; 30 for 04/06/09/11.
  - February: 29 when the BCD year is divisible by 4 (00 counts as leap), otherwise 28.
  - Day inc/dec wraps at that maximum.
  - After a month or year change, a day above the new maximum is clamped to it on the next cycle.
  - COMMIT is not entered until any pending clamp has completed.
- Not defined: day maximum is fixed at 31 and no clamping is done.

Decomposition:
- Package date_edit_pkg holds:
  - the state enum (IDLE/EDIT/COMMIT);
  - cursor codes CUR_DAY/CUR_MON/CUR_YEAR;
  - BCD limits DAY_MIN/DAY_MAX, MON_MIN/MON_MAX, YEAR_MIN/YEAR_MAX;
  - the days-in-month table.
- One sub-module, bcd_field_step: combinational packed-BCD inc/dec with min/max wrap and the out-of-range rule. Instantiated once, muxed by the cursor.

Test Plan:
- Pass-through: reset low 2 cycles, then reset high with programar_on = 0, fecha_in = 15/08/24 → fecha_out = 15/08/24 one cycle later; cursor = 3; wr_req = 0.
- Edit and commit: programar_on = 1; up ×2 on day 31 → 02; right then down on month 01 → 12; programar_on = 0 → wr_req = 1 with 02/12/24; wr_ack after 5 cycles → wr_req = 0 next cycle, IDLE.
- Cursor and simultaneous events: left from cursor 3 → 5; up+down together → no change; up+right together → field incremented, cursor unchanged.
- Timeout: commit with wr_ack held 0, ACK_TIMEOUT = 8 → wr_req drops after 8 cycles; wr_err pulses exactly once.
- Reset mid-COMMIT: wr_req = 1, reset low for 1 cycle → wr_req = 0, all outputs at reset values, no wr_err.
- With DATE_EDIT_DAYCLAMP_EN: day 31, month 03, down on month → month 02, day 29 (year 24); day 29 with year 24 → 23 → day 28.
